dense_mac_layer: RTL and testbench

Parametrised fixed-point dense (fully-connected) layer core with N_IN inputs and N_OUT outputs. It time-multiplexes a single signed MAC over all weight/input pairs, then adds a bias, rescales, optionally applies ReLU, and saturates. Weights and biases sit in a runtime-loadable register file. The core uses the same ap_start/ap_done/ap_idle/ap_ready block-level handshake as the existing layer blocks, so it drops into the same layer chain.

---
 rtl/dense_pkg.sv | 39 +++
 rtl/dense_mac_unit.sv | 53 +++++
 rtl/dense_mac_layer.sv | 170 +++++++++++++++++
 tb/tb_dense_mac_layer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared types and helpers for the dense MAC layer core.
package dense_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_VLD,
      S_MAC,
      S_FINAL,
      S_DONE
   } state_e;

   // Working width for the shift/saturate helper; accumulators up to 64 bits fit.
   localparam int SAT_W = 64;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

   // Arithmetic right shift (floor toward -inf) followed by clamp to a dw-bit signed range.
   function automatic logic signed [SAT_W-1:0] sat_shift(
      input logic signed [SAT_W-1:0] acc,
      input int                      frac,
      input int                      dw
   );
      logic signed [SAT_W-1:0] sh;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      sh = acc >>> frac;
      hi = (SAT_W'(1) <<< (dw - 1)) - SAT_W'(1);
      lo = -hi - SAT_W'(1);
      if (sh > hi) return hi;
      if (sh < lo) return lo;
      return sh;
   endfunction

endpackage

// File: rtl/dense_mac_unit.sv
// Signed multiply-accumulate with combinational neuron finalisation
// (bias add, floor shift, optional ReLU, saturation).
module dense_mac_unit
   import dense_pkg::*;
#(
   parameter int DW    = 16,
   parameter int FRAC  = 10,
   parameter int ACC_W = 40,
   parameter int RELU  = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 en_i,
   input  logic                 last_i,
   input  logic signed [DW-1:0] w_i,
   input  logic signed [DW-1:0] x_i,
   input  logic signed [DW-1:0] bias_i,
   output logic signed [DW-1:0] result_o
);

   logic signed [2*DW-1:0]  prod;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] bias_ext;
   logic signed [ACC_W-1:0] fin;
   logic signed [SAT_W-1:0] fin_wide;
   logic signed [SAT_W-1:0] sat;
   logic signed [DW-1:0]    sat_dw;

   always_comb begin
      prod     = (2*DW)'(w_i) * (2*DW)'(x_i);
      sum      = acc_q + ACC_W'(prod);
      // Bias is stored in output Q format, so align it with the product scale first.
      bias_ext = ACC_W'(bias_i) <<< FRAC;
      fin      = sum + bias_ext;
      fin_wide = SAT_W'(fin);
      sat      = sat_shift(fin_wide, FRAC, DW);
      sat_dw   = sat[DW-1:0];
      result_o = ((RELU != 0) && sat_dw[DW-1]) ? '0 : sat_dw;
   end

   always_comb begin
      acc_d = acc_q;
      if (en_i) acc_d = last_i ? '0 : sum;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) acc_q <= '0;
      else          acc_q <= acc_d;
   end

endmodule

// File: rtl/dense_mac_layer.sv
// Fully-connected layer core: one time-multiplexed MAC, runtime weight/bias
// register file and ap_start/ap_done block handshake.
//
// state      | meaning
// S_IDLE     | waiting for ap_start; config writes accepted
// S_WAIT_VLD | started, waiting for input_V_ap_vld
// S_MAC      | one weight*input product per cycle, neuron finalised on last input
// S_FINAL    | commit neuron results to layer_out_V
// S_DONE     | one-cycle ap_done / layer_out_V_ap_vld pulse
module dense_mac_layer
   import dense_pkg::*;
#(
   parameter int N_IN  = 2,
   parameter int N_OUT = 1,
   parameter int DW    = 16,
   parameter int FRAC  = 10,
   parameter int ACC_W = 40,
   parameter int RELU  = 0
) (
   input  logic                                    ap_clk,
   input  logic                                    ap_rst_n,
   input  logic                                    ap_start,
   output logic                                    ap_done,
   output logic                                    ap_idle,
   output logic                                    ap_ready,
   input  logic                                    input_V_ap_vld,
   input  logic [N_IN*DW-1:0]                      input_V,
   input  logic                                    cfg_we,
   input  logic [clog2(N_IN*N_OUT+N_OUT)-1:0]      cfg_addr,
   input  logic [DW-1:0]                           cfg_wdata,
   output logic [N_OUT*DW-1:0]                     layer_out_V,
   output logic                                    layer_out_V_ap_vld
);

   localparam int N_W   = N_IN * N_OUT;
   localparam int N_CFG = N_W + N_OUT;
   localparam int AW    = clog2(N_CFG);
   localparam int IW    = clog2(N_IN);
   localparam int OW    = clog2(N_OUT);

   state_e               state_q, state_d;
   logic [IW-1:0]        i_q, i_d;
   logic [OW-1:0]        o_q, o_d;
   logic signed [DW-1:0] cfg_q [N_CFG];
   logic signed [DW-1:0] out_q [N_OUT];
   logic [N_IN*DW-1:0]   x_q;
   logic [N_OUT*DW-1:0]  out_v_q;

   logic                 capture;
   logic                 mac_en;
   logic                 i_last;
   logic                 o_last;
   logic signed [DW-1:0] w_sel;
   logic signed [DW-1:0] x_sel;
   logic signed [DW-1:0] b_sel;
   logic signed [DW-1:0] res;

   assign i_last = (i_q == IW'(N_IN - 1));
   assign o_last = (o_q == OW'(N_OUT - 1));

   always_comb begin
      w_sel = '0;
      x_sel = '0;
      b_sel = '0;
      for (int k = 0; k < N_W; k++)
         if (k == int'(o_q) * N_IN + int'(i_q)) w_sel = cfg_q[k];
      for (int k = 0; k < N_IN; k++)
         if (i_q == IW'(k)) x_sel = x_q[k*DW +: DW];
      for (int k = 0; k < N_OUT; k++)
         if (o_q == OW'(k)) b_sel = cfg_q[N_W + k];
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      o_d     = o_q;
      capture = 1'b0;
      mac_en  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ap_start) begin
               if (input_V_ap_vld) begin
                  capture = 1'b1;
                  state_d = S_MAC;
               end else begin
                  state_d = S_WAIT_VLD;
               end
            end
         end
         S_WAIT_VLD: begin
            if (input_V_ap_vld) begin
               capture = 1'b1;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            mac_en = 1'b1;
            if (i_last) begin
               i_d = '0;
               if (o_last) begin
                  o_d     = '0;
                  state_d = S_FINAL;
               end else begin
                  o_d = o_q + OW'(1);
               end
            end else begin
               i_d = i_q + IW'(1);
            end
         end
         S_FINAL: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         o_q     <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         o_q     <= o_d;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         x_q     <= '0;
         out_v_q <= '0;
         for (int k = 0; k < N_CFG; k++) cfg_q[k] <= '0;
         for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
      end else begin
         if (capture) x_q <= input_V;
         // Addresses beyond the map match no entry and are silently dropped.
         if (state_q == S_IDLE && cfg_we)
            for (int k = 0; k < N_CFG; k++)
               if (cfg_addr == AW'(k)) cfg_q[k] <= cfg_wdata;
         if (mac_en && i_last)
            for (int k = 0; k < N_OUT; k++)
               if (o_q == OW'(k)) out_q[k] <= res;
         if (state_q == S_FINAL)
            for (int k = 0; k < N_OUT; k++) out_v_q[k*DW +: DW] <= out_q[k];
      end
   end

   dense_mac_unit #(
      .DW    (DW),
      .FRAC  (FRAC),
      .ACC_W (ACC_W),
      .RELU  (RELU)
   ) u_mac (
      .clk_i    (ap_clk),
      .rst_n_i  (ap_rst_n),
      .en_i     (mac_en),
      .last_i   (i_last),
      .w_i      (w_sel),
      .x_i      (x_sel),
      .bias_i   (b_sel),
      .result_o (res)
   );

   assign ap_ready           = capture;
   assign ap_idle            = (state_q == S_IDLE);
   assign ap_done            = (state_q == S_DONE);
   assign layer_out_V_ap_vld = ap_done;
   assign layer_out_V        = out_v_q;

endmodule

// File: tb/tb_dense_mac_layer.sv
// Directed bench for dense_mac_layer: 2x1 cores with and without ReLU plus a 4x2 core.
module tb_dense_mac_layer;

   logic ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   logic        rst_n, start, vld, cfg_we;
   logic [31:0] x_v;
   logic [1:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic        done, idle, ready, out_vld;
   logic [15:0] out_v;
   logic        r_done, r_idle, r_ready, r_ovld;
   logic [15:0] r_out;

   logic        b_rst_n, b_start, b_vld, b_we;
   logic [63:0] b_x;
   logic [3:0]  b_addr;
   logic [15:0] b_wdata;
   logic        b_done, b_idle, b_ready, b_ovld;
   logic [31:0] b_out;

   int tests = 0;
   int fails = 0;

   dense_mac_layer #(.N_IN(2), .N_OUT(1), .DW(16), .FRAC(10), .ACC_W(40), .RELU(0)) u_dut (
      .ap_clk(ap_clk), .ap_rst_n(rst_n), .ap_start(start), .ap_done(done), .ap_idle(idle),
      .ap_ready(ready), .input_V_ap_vld(vld), .input_V(x_v), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .layer_out_V(out_v),
      .layer_out_V_ap_vld(out_vld));

   dense_mac_layer #(.N_IN(2), .N_OUT(1), .DW(16), .FRAC(10), .ACC_W(40), .RELU(1)) u_relu (
      .ap_clk(ap_clk), .ap_rst_n(rst_n), .ap_start(start), .ap_done(r_done), .ap_idle(r_idle),
      .ap_ready(r_ready), .input_V_ap_vld(vld), .input_V(x_v), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .layer_out_V(r_out),
      .layer_out_V_ap_vld(r_ovld));

   dense_mac_layer #(.N_IN(4), .N_OUT(2), .DW(16), .FRAC(10), .ACC_W(40), .RELU(0)) u_big (
      .ap_clk(ap_clk), .ap_rst_n(b_rst_n), .ap_start(b_start), .ap_done(b_done), .ap_idle(b_idle),
      .ap_ready(b_ready), .input_V_ap_vld(b_vld), .input_V(b_x), .cfg_we(b_we),
      .cfg_addr(b_addr), .cfg_wdata(b_wdata), .layer_out_V(b_out),
      .layer_out_V_ap_vld(b_ovld));

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic bwr(input logic [3:0] a, input logic [15:0] d);
      b_we = 1'b1; b_addr = a; b_wdata = d;
      tick();
      b_we = 1'b0;
   endtask

   // lat counts cycles from the ap_ready cycle to the ap_done cycle.
   task automatic run(input logic [31:0] xv, output logic rdy, output int lat,
                      output logic [15:0] res, output logic [15:0] rres);
      start = 1'b1; vld = 1'b1; x_v = xv;
      #1 rdy = ready;
      tick();
      start = 1'b0; vld = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      res = out_v; rres = r_out;
      tick();
   endtask

   task automatic brun(input logic [63:0] xv, output int lat, output logic [31:0] res);
      b_start = 1'b1; b_vld = 1'b1; b_x = xv;
      tick();
      b_start = 1'b0; b_vld = 1'b0;
      lat = 1;
      while (b_done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      res = b_out;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; b_rst_n = 1'b0;
      start = 1'b0; vld = 1'b0; x_v = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      b_start = 1'b0; b_vld = 1'b0; b_x = '0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      tick(); tick();
      tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle got=%b exp=1", idle); end
      tests++; if (done !== 1'b0 || out_vld !== 1'b0) begin fails++; $display("FAIL reset_done got=%b/%b exp=0/0", done, out_vld); end
      tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", ready); end
      tests++; if (out_v !== 16'd0) begin fails++; $display("FAIL reset_out got=%h exp=0000", out_v); end
      tests++; if (b_idle !== 1'b1 || b_out !== 32'd0) begin fails++; $display("FAIL reset_big got=%b/%h exp=1/00000000", b_idle, b_out); end
      rst_n = 1'b1; b_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic rdy; int lat; logic [15:0] res, rres;
      wr(2'd0, 16'(-288)); wr(2'd1, 16'd304); wr(2'd2, 16'd157);
      run({16'd2048, 16'd1024}, rdy, lat, res, rres);
      tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL basic_ready got=%b exp=1", rdy); end
      tests++; if (lat != 4) begin fails++; $display("FAIL basic_latency got=%0d exp=4", lat); end
      tests++; if (res !== 16'd477) begin fails++; $display("FAIL basic_result got=%0d exp=477", $signed(res)); end
      tests++; if (rres !== 16'd477) begin fails++; $display("FAIL basic_relu_result got=%0d exp=477", $signed(rres)); end
      tests++; if (out_v !== 16'd477 || idle !== 1'b1 || done !== 1'b0) begin
         fails++; $display("FAIL basic_hold got=%0d idle=%b done=%b exp=477 1 0", $signed(out_v), idle, done); end
   endtask

   task automatic test_wait_vld();
      int bad, lat; logic rdy;
      start = 1'b1; vld = 1'b0; x_v = {16'd2048, 16'd1024};
      #1;
      tests++; if (ready !== 1'b0) begin fails++; $display("FAIL wait_ready_early got=%b exp=0", ready); end
      tick();
      start = 1'b0;
      bad = 0;
      repeat (5) begin
         if (idle !== 1'b0 || ready !== 1'b0 || done !== 1'b0) bad++;
         tick();
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL wait_hold bad_cycles=%0d exp=0", bad); end
      vld = 1'b1;
      #1 rdy = ready;
      tick();
      vld = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 20) begin tick(); lat++; end
      tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL wait_ready got=%b exp=1", rdy); end
      tests++; if (lat != 4 || out_v !== 16'd477) begin
         fails++; $display("FAIL wait_result got=%0d lat=%0d exp=477 lat=4", $signed(out_v), lat); end
      tick();
   endtask

   task automatic test_saturation();
      logic rdy; int lat; logic [15:0] res, rres;
      wr(2'd0, 16'd32767); wr(2'd1, 16'd32767); wr(2'd2, 16'd0);
      run({16'd32767, 16'd32767}, rdy, lat, res, rres);
      tests++; if (res !== 16'h7fff) begin fails++; $display("FAIL sat_pos got=%h exp=7fff", res); end
      wr(2'd0, 16'h8000); wr(2'd1, 16'h8000);
      run({16'd32767, 16'd32767}, rdy, lat, res, rres);
      tests++; if (res !== 16'h8000) begin fails++; $display("FAIL sat_neg got=%h exp=8000", res); end
      tests++; if (rres !== 16'h0000) begin fails++; $display("FAIL sat_neg_relu got=%h exp=0000", rres); end
   endtask

   task automatic test_floor_relu();
      logic rdy; int lat; logic [15:0] res, rres;
      wr(2'd0, 16'd1); wr(2'd1, 16'd0); wr(2'd2, 16'd0);
      run({16'd0, 16'hffff}, rdy, lat, res, rres);
      tests++; if (res !== 16'hffff) begin fails++; $display("FAIL floor_m1 got=%h exp=ffff", res); end
      tests++; if (rres !== 16'h0000) begin fails++; $display("FAIL relu_m1 got=%h exp=0000", rres); end
      run({16'd0, 16'(-1025)}, rdy, lat, res, rres);
      tests++; if (res !== 16'hfffe) begin fails++; $display("FAIL floor_m1025 got=%h exp=fffe", res); end
      run({16'd0, 16'd1023}, rdy, lat, res, rres);
      tests++; if (res !== 16'h0000) begin fails++; $display("FAIL floor_p1023 got=%h exp=0000", res); end
   endtask

   task automatic test_cfg_guard();
      logic rdy; int lat; logic [15:0] res, rres;
      wr(2'd0, 16'(-288)); wr(2'd1, 16'd304); wr(2'd2, 16'd157);
      start = 1'b1; vld = 1'b1; x_v = {16'd2048, 16'd1024};
      tick();
      start = 1'b0; vld = 1'b0;
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 16'd0;
      tick();
      cfg_we = 1'b0;
      lat = 2;
      while (done !== 1'b1 && lat < 20) begin tick(); lat++; end
      tests++; if (out_v !== 16'd477) begin fails++; $display("FAIL guard_mac_run got=%0d exp=477", $signed(out_v)); end
      tick();
      run({16'd2048, 16'd1024}, rdy, lat, res, rres);
      tests++; if (res !== 16'd477) begin fails++; $display("FAIL guard_mac_kept got=%0d exp=477", $signed(res)); end
      wr(2'd3, 16'd1234);
      run({16'd2048, 16'd1024}, rdy, lat, res, rres);
      tests++; if (res !== 16'd477) begin fails++; $display("FAIL guard_oob got=%0d exp=477", $signed(res)); end
   endtask

   task automatic test_reset_mid_mac();
      int lat, bad; logic [31:0] res;
      for (int a = 0; a < 4; a++) bwr(4'(a), 16'd1024);
      for (int a = 4; a < 8; a++) bwr(4'(a), 16'd2048);
      bwr(4'd8, 16'd1);
      brun({16'd4, 16'd3, 16'd2, 16'd1}, lat, res);
      tests++; if (lat != 10) begin fails++; $display("FAIL big_latency got=%0d exp=10", lat); end
      tests++; if (res !== {16'd20, 16'd11}) begin fails++; $display("FAIL big_result got=%h exp=0014000b", res); end
      b_start = 1'b1; b_vld = 1'b1; b_x = {16'd4, 16'd3, 16'd2, 16'd1};
      tick();
      b_start = 1'b0; b_vld = 1'b0;
      tick(); tick();
      b_rst_n = 1'b0;
      tick();
      tests++; if (b_idle !== 1'b1 || b_done !== 1'b0 || b_ovld !== 1'b0) begin
         fails++; $display("FAIL midrst_state idle=%b done=%b vld=%b exp=1 0 0", b_idle, b_done, b_ovld); end
      tests++; if (b_out !== 32'd0) begin fails++; $display("FAIL midrst_out got=%h exp=00000000", b_out); end
      b_rst_n = 1'b1;
      bad = 0;
      repeat (12) begin
         if (b_done !== 1'b0 || b_idle !== 1'b1) bad++;
         tick();
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL midrst_no_done bad_cycles=%0d exp=0", bad); end
      brun({16'd4, 16'd3, 16'd2, 16'd1}, lat, res);
      tests++; if (lat != 10 || res !== 32'd0) begin
         fails++; $display("FAIL midrst_cleared got=%h lat=%0d exp=00000000 lat=10", res, lat); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wait_vld();
      test_saturation();
      test_floor_relu();
      test_cfg_guard();
      test_reset_mid_mac();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout sim_time=%0t limit=200000", $time);
      $fatal(1, "timeout");
   end

endmodule
